// File: rtl/i2c_target_eeprom_pkg.sv
// Shared definitions for the I2C EEPROM target: FSM state encoding, bus
// acknowledge levels and bit-count landmarks.
package i2c_target_eeprom_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_ACK_DEV,
    ST_WORD_ADDR,
    ST_ACK_WORD,
    ST_WRITE_DATA,
    ST_ACK_DATA,
    ST_READ_DATA,
    ST_READ_ACK
  } state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [3:0] LAST_BIT  = 4'd7;
  localparam logic [3:0] BYTE_DONE = 4'd8;

  // Where an ACK slot hands over once SDA is released.
  function automatic state_e ack_next(input state_e s);
    return (s == ST_ACK_DEV) ? ST_WORD_ADDR : ST_WRITE_DATA;
  endfunction

endpackage

// File: rtl/i2c_target_eeprom_if.sv
// Pin-side I2C signals between the pad primitive (master modport: drives the
// raw pin inputs) and the EEPROM target (slave modport: drives the pulldowns).
interface i2c_target_eeprom_if;
  logic SCL_DIN;
  logic SDA_DIN;
  logic SDA_PULLDOWN;
  logic SCL_PULLDOWN;

  modport master (output SCL_DIN, SDA_DIN, input SDA_PULLDOWN, SCL_PULLDOWN);
  modport slave  (input SCL_DIN, SDA_DIN, output SDA_PULLDOWN, SCL_PULLDOWN);
endinterface

// File: rtl/i2c_target_eeprom_bus_monitor.sv
// I2C bus front end: 2-flop synchronisers on SCL/SDA and edge/START/STOP
// strobes derived against a one-cycle-delayed copy of the synchronised lines.
module i2c_bus_monitor (
  input  logic clk,
  input  logic rst,
  input  logic scl_din,
  input  logic sda_din,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_sync
);

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d;
  logic       sda_prev_q, sda_prev_d;
  logic       scl_s;

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_din};
    sda_sync_d = {sda_sync_q[0], sda_din};
    scl_prev_d = scl_sync_q[1];
    sda_prev_d = sda_sync_q[1];
  end

  // Reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_s     = scl_sync_q[1];
  assign sda_sync  = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_sync;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_sync;

endmodule

// File: rtl/i2c_target_eeprom.sv
// I2C target emulating a 24Cxx-style byte-addressed EEPROM of 2**ADDR_W bytes
// with auto-incrementing pointer; no clock stretching.
module i2c_target_eeprom
  import i2c_target_eeprom_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         ADDR_W   = 4
) (
  input  logic                ICE_CLK,
  input  logic                RST,
  i2c_target_eeprom_if.slave  bus,
  output logic                WR_STB,
  output logic [ADDR_W-1:0]   WR_ADDR,
  output logic [7:0]          WR_DATA,
  output logic                BUSY
);

  localparam int DEPTH = 1 << ADDR_W;

  logic scl_rise, scl_fall, start_det, stop_det, sda;

  i2c_bus_monitor u_mon (
    .clk       (ICE_CLK),
    .rst       (RST),
    .scl_din   (bus.SCL_DIN),
    .sda_din   (bus.SDA_DIN),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_sync  (sda)
  );

  state_e              state_q, state_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                rw_q, rw_d;
  logic                sda_pd_q, sda_pd_d;
  logic                busy_q, busy_d;
  logic                wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                mem_we;
  logic [7:0]          rx_byte;
  logic [7:0]          rd_data_q;
  logic [7:0]          mem [DEPTH];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sda_pd_d  = sda_pd_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;
    rx_byte   = {shift_q[6:0], sda};

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_pd_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d   = ST_DEV_ADDR;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_DEV_ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              if (rx_byte[7:1] == DEV_ADDR) begin
                state_d = ST_ACK_DEV;
                busy_d  = 1'b1;
                rw_d    = rx_byte[0];
              end else begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
              end
            end
          end
        end

        ST_WORD_ADDR, ST_WRITE_DATA: begin
          if (scl_rise && bit_cnt_q != BYTE_DONE) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (state_q == ST_WORD_ADDR && bit_cnt_q == LAST_BIT) begin
              ptr_d     = rx_byte[ADDR_W-1:0];
              state_d   = ST_ACK_WORD;
              bit_cnt_d = '0;
            end
          end else if (scl_fall && state_q == ST_WRITE_DATA && bit_cnt_q == BYTE_DONE) begin
            // Commit only once all 8 bits arrived; the ACK starts on this same fall.
            mem_we    = 1'b1;
            wr_stb_d  = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = shift_q;
            ptr_d     = ptr_q + 1'b1;
            sda_pd_d  = 1'b1;
            state_d   = ST_ACK_DATA;
            bit_cnt_d = 4'd1;
          end
        end

        // bit_cnt: 0 = waiting to pull, 1 = pulling, 2 = ninth clock seen.
        ST_ACK_DEV, ST_ACK_WORD, ST_ACK_DATA: begin
          if (scl_fall && bit_cnt_q == 4'd0) begin
            sda_pd_d  = 1'b1;
            bit_cnt_d = 4'd1;
          end else if (scl_rise) begin
            bit_cnt_d = 4'd2;
            if (state_q == ST_ACK_DEV && rw_q) begin
              shift_d   = rd_data_q;
              ptr_d     = ptr_q + 1'b1;
              state_d   = ST_READ_DATA;
              bit_cnt_d = '0;
            end
          end else if (scl_fall && bit_cnt_q == 4'd2) begin
            sda_pd_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = ack_next(state_q);
          end
        end

        ST_READ_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == BYTE_DONE) begin
              sda_pd_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_READ_ACK;
            end else begin
              sda_pd_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        ST_READ_ACK: begin
          if (scl_rise) begin
            if (sda == I2C_ACK) begin
              shift_d   = rd_data_q;
              ptr_d     = ptr_q + 1'b1;
              state_d   = ST_READ_DATA;
              bit_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge ICE_CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      sda_pd_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      sda_pd_q  <= sda_pd_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Contents survive RST; the read port tracks the pointer one cycle behind.
  always_ff @(posedge ICE_CLK) begin
    if (mem_we) mem[ptr_q] <= shift_q;
    rd_data_q <= mem[ptr_q];
  end

  assign bus.SDA_PULLDOWN = sda_pd_q;
  assign bus.SCL_PULLDOWN = 1'b0;
  assign WR_STB  = wr_stb_q;
  assign WR_ADDR = wr_addr_q;
  assign WR_DATA = wr_data_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_i2c_target_eeprom.sv
// Randomised bench for i2c_target_eeprom: a bit-banged open-drain I2C master
// plus a byte-level EEPROM model (array + pointer) predicting every response.
module tb_i2c_target_eeprom;

  localparam logic [6:0] DEV = 7'h50;
  localparam int AW = 4;
  localparam int Q  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic msda = 1'b1;
  logic wr_stb, busy;
  logic [AW-1:0] wr_addr;
  logic [7:0] wr_data;

  i2c_target_eeprom_if bus();
  assign bus.SCL_DIN = scl;
  assign bus.SDA_DIN = msda & ~bus.SDA_PULLDOWN;

  i2c_target_eeprom #(.DEV_ADDR(DEV), .ADDR_W(AW)) dut (
    .ICE_CLK (clk),
    .RST     (rst),
    .bus     (bus.slave),
    .WR_STB  (wr_stb),
    .WR_ADDR (wr_addr),
    .WR_DATA (wr_data),
    .BUSY    (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  int tests = 0;
  int fails = 0;
  logic [7:0] mem_m [16];
  logic [3:0] ptr_m = 4'd0;
  logic [7:0] wbuf [16];
  logic [7:0] rbuf [16];
  wr_t exp_wr [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Every write strobe must match the oldest byte the model expects to land.
  always @(negedge clk) begin
    if (!rst && wr_stb) begin
      wr_t e;
      if (exp_wr.size() == 0) begin
        check("unexpected_wr_stb", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_wr.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.a));
        check("wr_data", 32'(wr_data), 32'(e.d));
      end
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL timeout: run still going, want finished");
    $fatal(1, "bench timeout");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    wait_clks(Q); msda = b;
    wait_clks(Q); scl = 1'b1;
    wait_clks(Q); s = bus.SDA_DIN;
    wait_clks(Q); scl = 1'b0;
  endtask

  task automatic i2c_start();
    wait_clks(Q); msda = 1'b1;
    wait_clks(Q); scl = 1'b1;
    wait_clks(Q); msda = 1'b0;
    wait_clks(Q); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clks(Q); msda = 1'b0;
    wait_clks(Q); scl = 1'b1;
    wait_clks(Q); msda = 1'b1;
    wait_clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    logic s;
    logic [7:0] seen;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(b[i], s);
      seen[i] = s;
    end
    check({nm, "_line_undriven"}, 32'(seen), 32'(b));
    bit_xfer(1'b1, s);
    check({nm, "_ack"}, 32'(s), exp_ack ? 32'd0 : 32'd1);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    logic s;
    for (int i = 0; i < n; i++) bit_xfer(b[7-i], s);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] r);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      r[i] = s;
    end
    bit_xfer(nack, s);
    check("master_ack_slot_free", 32'(s), 32'(nack));
  endtask

  task automatic do_write(input logic [7:0] waddr, input int n);
    i2c_start();
    send_byte({DEV, 1'b0}, 1'b1, "dev_w");
    check("busy_after_match", 32'(busy), 32'd1);
    send_byte(waddr, 1'b1, "word_addr");
    ptr_m = waddr[3:0];
    for (int i = 0; i < n; i++) begin
      exp_wr.push_back(wr_t'{ptr_m, wbuf[i]});
      mem_m[ptr_m] = wbuf[i];
      ptr_m = ptr_m + 4'd1;
      send_byte(wbuf[i], 1'b1, "data_w");
    end
    i2c_stop();
    check("busy_after_stop", 32'(busy), 32'd0);
    check("writes_all_seen", 32'(exp_wr.size()), 32'd0);
  endtask

  task automatic do_read(input logic random_rd, input logic [7:0] waddr, input int n);
    logic [7:0] r;
    if (random_rd) begin
      i2c_start();
      send_byte({DEV, 1'b0}, 1'b1, "dev_w");
      send_byte(waddr, 1'b1, "word_addr");
      ptr_m = waddr[3:0];
    end
    i2c_start();
    send_byte({DEV, 1'b1}, 1'b1, "dev_r");
    check("busy_in_read", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, r);
      check("read_data", 32'(r), 32'(mem_m[ptr_m]));
      rbuf[i] = r;
      ptr_m = ptr_m + 4'd1;
    end
    wait_clks(Q);
    check("sda_released_after_nack", 32'(bus.SDA_PULLDOWN), 32'd0);
    check("busy_after_nack", 32'(busy), 32'd0);
    i2c_stop();
  endtask

  task automatic wrong_addr(input logic [7:0] abyte, input logic [7:0] junk);
    i2c_start();
    send_byte(abyte, 1'b0, "foreign_addr");
    check("busy_foreign", 32'(busy), 32'd0);
    send_byte(junk, 1'b0, "foreign_data");
    i2c_stop();
  endtask

  task automatic aborted_write(input logic [7:0] waddr, input logic [7:0] b, input int nbits);
    i2c_start();
    send_byte({DEV, 1'b0}, 1'b1, "dev_w");
    send_byte(waddr, 1'b1, "word_addr");
    ptr_m = waddr[3:0];
    send_bits(b, nbits);
    i2c_stop();
    check("busy_after_abort", 32'(busy), 32'd0);
  endtask

  initial begin
    wait_clks(3);
    check("rst_sda_pd", 32'(bus.SDA_PULLDOWN), 32'd0);
    check("rst_scl_pd", 32'(bus.SCL_PULLDOWN), 32'd0);
    check("rst_wr_stb", 32'(wr_stb), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_clks(4);

    // Give every location a known value.
    for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
    do_write(8'h00, 16);

    // Two-byte write at 3, then random read back.
    wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
    do_write(8'h03, 2);
    check("t1_last_wr_addr", 32'(wr_addr), 32'd4);
    check("t1_last_wr_data", 32'(wr_data), 32'hC3);
    do_read(1'b1, 8'h03, 2);
    check("t2_byte0", 32'(rbuf[0]), 32'h5A);
    check("t2_byte1", 32'(rbuf[1]), 32'hC3);

    // Foreign address 0x51 must be ignored.
    wrong_addr(8'hA2, 8'h00);

    // Pointer wraps from 15 to 0; current read continues at 1.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    do_write(8'h0F, 2);
    check("t4_last_wr_addr", 32'(wr_addr), 32'd0);
    check("t4_model_ptr", 32'(ptr_m), 32'd1);
    do_read(1'b0, 8'h00, 1);

    // Byte cut short after 5 bits is never written.
    aborted_write(8'h07, 8'hFF, 5);
    do_read(1'b1, 8'h07, 1);

    // Reset while the target is pulling SDA low for a 0 read bit.
    wbuf[0] = 8'h3C;
    do_write(8'h02, 1);
    i2c_start();
    send_byte({DEV, 1'b0}, 1'b1, "dev_w");
    send_byte(8'h02, 1'b1, "word_addr");
    i2c_start();
    send_byte({DEV, 1'b1}, 1'b1, "dev_r");
    wait_clks(Q);
    check("t6_driving_zero", 32'(bus.SDA_PULLDOWN), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_release", 32'(bus.SDA_PULLDOWN), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_wr_addr", 32'(wr_addr), 32'd0);
    wait_clks(2);
    rst = 1'b0;
    msda = 1'b1;
    wait_clks(Q);
    scl = 1'b1;
    ptr_m = 4'd0;
    wait_clks(4 * Q);
    do_read(1'b0, 8'h00, 2);

    // Randomised traffic against the model.
    for (int it = 0; it < 25; it++) begin
      int op;
      int n;
      logic [6:0] a;
      op = $urandom_range(0, 4);
      n  = $urandom_range(1, 4);
      case (op)
        0: begin
          for (int j = 0; j < n; j++) wbuf[j] = 8'($urandom);
          do_write(8'($urandom), n);
        end
        1: do_read(1'b1, 8'($urandom), n);
        2: do_read(1'b0, 8'h00, n);
        3: begin
          a = 7'($urandom);
          if (a == DEV) a = DEV + 7'd1;
          wrong_addr({a, 1'($urandom)}, 8'($urandom));
        end
        default: aborted_write(8'($urandom), 8'($urandom), $urandom_range(1, 7));
      endcase
    end

    check("no_pending_writes", 32'(exp_wr.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
